// File: rtl/sr_trigger_gen.sv
// Ultrasonic ranger transmit side: TRIG pulse, echo window supervision and inter-shot holdoff.
// Define SR_TRIG_CONT_MODE_EN for free-running shots; default build is single-shot on START.
module sr_trigger_gen #(
   parameter int unsigned CNT_W            = 16,
   parameter int unsigned TRIG_CYCLES      = 10,
   parameter int unsigned ECHO_WAIT_CYCLES = 1000,
   parameter int unsigned ECHO_MAX_CYCLES  = 38000,
   parameter int unsigned HOLDOFF_CYCLES   = 60000
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic sr_echo,
   output logic sr_trig,
   output logic busy,
   output logic echo_active,
   output logic done,
   output logic timeout
);

   typedef enum logic [2:0] {
      StIdle,
      StTrig,
      StWaitEcho,
      StEcho,
      StHoldoff
   } state_e;

   localparam logic [CNT_W-1:0] TrigLast = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0] WaitLast = CNT_W'(ECHO_WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] EchoLast = CNT_W'(ECHO_MAX_CYCLES - 1);
   localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLDOFF_CYCLES - 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_inc;
   logic             echo_meta_q;
   logic             echo_s_q;
   logic             sr_trig_q;
   logic             busy_q;
   logic             echo_active_q;
   logic             done_q;
   logic             timeout_q;

   // Saturating increment so a mis-sized counter can never wrap inside a state.
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         echo_meta_q   <= 1'b0;
         echo_s_q      <= 1'b0;
         sr_trig_q     <= 1'b0;
         busy_q        <= 1'b0;
         echo_active_q <= 1'b0;
         done_q        <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         echo_meta_q <= sr_echo;
         echo_s_q    <= echo_meta_q;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q   <= StTrig;
                  cnt_q     <= '0;
                  sr_trig_q <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            StTrig: begin
               if (cnt_q == TrigLast) begin
                  state_q   <= StWaitEcho;
                  cnt_q     <= '0;
                  sr_trig_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            StWaitEcho: begin
               // A late echo on the deadline cycle still counts as a valid response.
               if (echo_s_q) begin
                  state_q       <= StEcho;
                  cnt_q         <= '0;
                  echo_active_q <= 1'b1;
               end else if (cnt_q == WaitLast) begin
                  state_q   <= StHoldoff;
                  cnt_q     <= '0;
                  timeout_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            StEcho: begin
               if (!echo_s_q) begin
                  state_q       <= StHoldoff;
                  cnt_q         <= '0;
                  echo_active_q <= 1'b0;
                  done_q        <= 1'b1;
               end else if (cnt_q == EchoLast) begin
                  state_q       <= StHoldoff;
                  cnt_q         <= '0;
                  echo_active_q <= 1'b0;
                  timeout_q     <= 1'b1;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            StHoldoff: begin
               if (cnt_q == HoldLast) begin
                  cnt_q <= '0;
`ifdef SR_TRIG_CONT_MODE_EN
                  state_q   <= StTrig;
                  sr_trig_q <= 1'b1;
`else
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
`endif
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            default: begin
               state_q <= StIdle;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign sr_trig     = sr_trig_q;
   assign busy        = busy_q;
   assign echo_active = echo_active_q;
   assign done        = done_q;
   assign timeout     = timeout_q;

endmodule
